sad_window_min: RTL and testbench

- Sequential consumer of the absolute-difference stream produced by the datapath's absolute-difference unit.
- Accumulates fixed-length windows of |A-B| values into a sum of absolute differences (SAD).
- Compares each window's SAD against the running best and reports the minimum SAD and the index of the window that produced it.
- Sits behind the absolute-difference unit in the SAD/motion-search path; its results are read by the controller at search end.

---
 rtl/sad_window_min_if.sv | 44 ++++
 rtl/sad_window_min.sv | 135 +++++++++++++
 tb/tb_sad_window_min.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_window_min_if.sv
// Handshake and result bundle between the abs-diff
// producer / controller and sad_window_min.
interface sad_window_min_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int IDX_WIDTH  = 16
);
  logic                  Start;
  logic                  DiffValid;
  logic [DATA_WIDTH-1:0] DiffIn;
  logic                  LastWindow;
  logic                  Ready;
  logic                  Busy;
  logic                  Done;
  logic [ACC_WIDTH-1:0]  MinSAD;
  logic [IDX_WIDTH-1:0]  MinIndex;
  logic [ACC_WIDTH-1:0]  CurSAD;

  modport master (
    output Start,
    output DiffValid,
    output DiffIn,
    output LastWindow,
    input  Ready,
    input  Busy,
    input  Done,
    input  MinSAD,
    input  MinIndex,
    input  CurSAD
  );

  modport slave (
    input  Start,
    input  DiffValid,
    input  DiffIn,
    input  LastWindow,
    output Ready,
    output Busy,
    output Done,
    output MinSAD,
    output MinIndex,
    output CurSAD
  );
endinterface

// File: rtl/sad_window_min.sv
// Windowed SAD accumulator with running minimum search.
// Reports best window SAD and its index at search end.
module sad_window_min #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int WINDOW_LEN = 16,
  parameter int IDX_WIDTH  = 16
) (
  input logic             Clk,
  input logic             Reset,
  sad_window_min_if.slave bus
);

  localparam int CNT_W = $clog2(WINDOW_LEN);
  localparam int SUM_W =
    ((DATA_WIDTH > ACC_WIDTH) ? DATA_WIDTH : ACC_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WINDOW_LEN - 1);
  localparam logic [SUM_W-1:0] ACC_MAX =
    SUM_W'({ACC_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    COMPARE,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] cur_sad_q, cur_sad_d;
  logic [ACC_WIDTH-1:0] min_sad_q, min_sad_d;
  logic [IDX_WIDTH-1:0] min_idx_q, min_idx_d;
  logic [IDX_WIDTH-1:0] win_idx_q, win_idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;

  logic [SUM_W-1:0]     sum_w;
  logic [ACC_WIDTH-1:0] sum_sat;

  // Widened add so overflow is visible, then clamp.
  always_comb begin
    sum_w = SUM_W'(cur_sad_q) + SUM_W'(bus.DiffIn);
    if (sum_w > ACC_MAX) begin
      sum_sat = '1;
    end else begin
      sum_sat = sum_w[ACC_WIDTH-1:0];
    end
  end

  // Next-state and datapath updates for the search FSM.
  always_comb begin
    state_d   = state_q;
    cur_sad_d = cur_sad_q;
    min_sad_d = min_sad_q;
    min_idx_d = min_idx_q;
    win_idx_d = win_idx_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    last_d    = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d   = ACCUM;
          cur_sad_d = '0;
          min_sad_d = '1;
          min_idx_d = '0;
          win_idx_d = '0;
          cnt_d     = '0;
          first_d   = 1'b1;
          last_d    = 1'b0;
        end
      end
      ACCUM: begin
        if (bus.DiffValid) begin
          cur_sad_d = sum_sat;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            last_d  = bus.LastWindow;
            state_d = COMPARE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      COMPARE: begin
        if (first_q || (cur_sad_q < min_sad_q)) begin
          min_sad_d = cur_sad_q;
          min_idx_d = win_idx_q;
        end
        first_d   = 1'b0;
        cur_sad_d = '0;
        win_idx_d = win_idx_q + IDX_WIDTH'(1);
        state_d   = last_q ? DONE : ACCUM;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cur_sad_q <= '0;
      min_sad_q <= '1;
      min_idx_q <= '0;
      win_idx_q <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sad_q <= cur_sad_d;
      min_sad_q <= min_sad_d;
      min_idx_q <= min_idx_d;
      win_idx_q <= win_idx_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  assign bus.Ready    = (state_q == ACCUM);
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = (state_q == DONE);
  assign bus.MinSAD   = min_sad_q;
  assign bus.MinIndex = min_idx_q;
  assign bus.CurSAD   = cur_sad_q;

endmodule

// File: tb/tb_sad_window_min.sv
// Directed and randomized bench for sad_window_min
// with a window-level reference model.
module tb_sad_window_min;

  localparam int WL = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sad_window_min_if #(
    .DATA_WIDTH(32),
    .ACC_WIDTH (32),
    .IDX_WIDTH (16)
  ) bus ();

  sad_window_min #(
    .DATA_WIDTH(32),
    .ACC_WIDTH (32),
    .WINDOW_LEN(WL),
    .IDX_WIDTH (16)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Window-level model: chunk, saturate, keep strict min.
  task automatic model(input  logic [31:0] e[$],
                       output logic [31:0] best,
                       output logic [15:0] bidx,
                       output logic [31:0] lsum);
    longint s;
    int nw;
    nw   = e.size() / WL;
    best = '1;
    bidx = '0;
    lsum = '0;
    for (int w = 0; w < nw; w++) begin
      s = 0;
      for (int k = 0; k < WL; k++) s += longint'(e[w*WL+k]);
      if (s > 64'h0_FFFF_FFFF) s = 64'h0_FFFF_FFFF;
      if (w == 0 || s < longint'(best)) begin
        best = s[31:0];
        bidx = 16'(w);
      end
      lsum = s[31:0];
    end
  endtask

  task automatic run_search(input string nm,
                            input logic [31:0] e[$],
                            input int early_pos,
                            input bit junk,
                            input bit hold_start);
    logic [31:0] best;
    logic [31:0] lsum;
    logic [15:0] bidx;
    int i;
    int stalls;
    int budget;
    bit early_done;
    bit tmo;
    i = 0;
    stalls = 0;
    budget = 0;
    early_done = 0;
    tmo = 0;
    model(e, best, bidx, lsum);
    bus.Start = 1'b1;
    tick();
    bus.Start = hold_start;
    chk({nm, ":start_min"}, 64'(bus.MinSAD), 64'hFFFF_FFFF);
    chk({nm, ":start_cur"}, 64'(bus.CurSAD), 64'h0);
    chk({nm, ":start_busy"}, 64'(bus.Busy), 64'h1);
    while (i < e.size()) begin
      if (bus.Done) early_done = 1;
      if (bus.Ready) begin
        bus.DiffValid  = 1'b1;
        bus.DiffIn     = e[i];
        bus.LastWindow = (i == e.size() - 1) || (i == early_pos);
        if (i == e.size() - 1) bus.Start = 1'b0;
        i++;
        budget = 0;
      end else begin
        stalls++;
        budget++;
        bus.DiffValid = 1'b1;
        if (junk) begin
          bus.DiffIn     = 32'h7000_0000 | $urandom_range(0, 255);
          bus.LastWindow = 1'b1;
        end
      end
      if (budget > 8) begin
        tmo = 1;
        break;
      end
      tick();
    end
    bus.DiffValid  = junk;
    bus.DiffIn     = 32'h7000_0001;
    bus.LastWindow = 1'b0;
    chk({nm, ":timeout"}, 64'(tmo), 64'h0);
    chk({nm, ":early_done"}, 64'(early_done), 64'h0);
    chk({nm, ":bubbles"}, 64'(stalls), 64'(e.size() / WL - 1));
    chk({nm, ":cmp_done"}, 64'(bus.Done), 64'h0);
    chk({nm, ":cmp_ready"}, 64'(bus.Ready), 64'h0);
    chk({nm, ":cmp_cur"}, 64'(bus.CurSAD), 64'(lsum));
    tick();
    chk({nm, ":done"}, 64'(bus.Done), 64'h1);
    chk({nm, ":min"}, 64'(bus.MinSAD), 64'(best));
    chk({nm, ":idx"}, 64'(bus.MinIndex), 64'(bidx));
    chk({nm, ":done_cur"}, 64'(bus.CurSAD), 64'h0);
    tick();
    bus.DiffValid = 1'b0;
    chk({nm, ":idle_done"}, 64'(bus.Done), 64'h0);
    chk({nm, ":idle_busy"}, 64'(bus.Busy), 64'h0);
    tick();
    chk({nm, ":hold_min"}, 64'(bus.MinSAD), 64'(best));
    chk({nm, ":hold_idx"}, 64'(bus.MinIndex), 64'(bidx));
  endtask

  // Feed elements without end-of-search checks.
  task automatic drive_n(input logic [31:0] e[$]);
    int i;
    int budget;
    i = 0;
    budget = 0;
    while (i < e.size() && budget <= 8) begin
      if (bus.Ready) begin
        bus.DiffValid  = 1'b1;
        bus.DiffIn     = e[i];
        bus.LastWindow = 1'b0;
        i++;
        budget = 0;
      end else begin
        bus.DiffValid = 1'b0;
        budget++;
      end
      tick();
    end
    bus.DiffValid = 1'b0;
    chk("drive_timeout", 64'(budget > 8), 64'h0);
  endtask

  initial begin
    logic [31:0] q[$];
    int nw;
    int ep;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.Start      = 1'b0;
    bus.DiffValid  = 1'b0;
    bus.DiffIn     = '0;
    bus.LastWindow = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 64'(bus.Ready), 64'h0);
    chk("rst_busy", 64'(bus.Busy), 64'h0);
    chk("rst_done", 64'(bus.Done), 64'h0);
    chk("rst_min", 64'(bus.MinSAD), 64'hFFFF_FFFF);
    chk("rst_idx", 64'(bus.MinIndex), 64'h0);
    chk("rst_cur", 64'(bus.CurSAD), 64'h0);

    q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd1, 32'd1};
    run_search("basic", q, -1, 0, 0);

    q = '{32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd5};
    run_search("tie", q, -1, 0, 0);

    q = '{32'hFFFF_FFF0, 32'h20, 32'd1, 32'd1};
    run_search("sat", q, -1, 0, 0);

    q = '{32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6,
          32'd5, 32'd3, 32'd5, 32'd8};
    run_search("backpr", q, -1, 1, 0);

    q = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd1, 32'd1, 32'd1, 32'd1,
          32'd5, 32'd5, 32'd5, 32'd5};
    run_search("start_ign", q, -1, 0, 1);

    q = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd2};
    run_search("early_last", q, 1, 0, 0);

    // Abort a search mid-window after one full window.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    q = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd10, 32'd20};
    drive_n(q);
    chk("mid_cur", 64'(bus.CurSAD), 64'd30);
    chk("mid_min", 64'(bus.MinSAD), 64'd16);
    rst = 1'b1;
    bus.DiffValid = 1'b1;
    bus.DiffIn    = 32'd99;
    tick();
    rst = 1'b0;
    bus.DiffValid = 1'b0;
    chk("abort_busy", 64'(bus.Busy), 64'h0);
    chk("abort_cur", 64'(bus.CurSAD), 64'h0);
    chk("abort_min", 64'(bus.MinSAD), 64'hFFFF_FFFF);
    chk("abort_done", 64'(bus.Done), 64'h0);
    tick();
    chk("abort_done2", 64'(bus.Done), 64'h0);
    chk("abort_busy2", 64'(bus.Busy), 64'h0);

    for (int r = 0; r < 8; r++) begin
      q = {};
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw * WL; k++) begin
        if ($urandom_range(0, 3) == 0)
          q.push_back($urandom);
        else
          q.push_back(32'($urandom_range(0, 100)));
      end
      ep = $urandom_range(0, nw * WL - 1);
      if ((ep % WL) == WL - 1) ep = -1;
      run_search($sformatf("rnd%0d", r), q, ep,
                 1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
